mas_seq_divider: RTL and testbench
==================================

Name: mas_seq_divider

Overview:
Sequential unsigned restoring divider, the inverse operation to the multiplier datapath.
- Produces one quotient bit per cycle.
- The trial subtract is a chain of 4-bit ripple-borrow slices: a + ~b + 1, carry-out = no-borrow.
- Valid/ready handshakes on the operand side and the result side.
- Sits beside the multiplier for normalisation and reciprocal-check paths.

Parameters:
WIDTH, 8, operand width in bits; must be a multiple of 4 and ≥4 (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  divider can accept operands
in1  input  WIDTH  dividend
in2  input  WIDTH  divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quo  output  WIDTH  quotient
rem  output  WIDTH  remainder
div_by_zero  output  1  divisor was zero for the presented result

Behaviour:
Reset (rst_n low, async):
- State goes to IDLE.
- in_ready=1, out_valid=0, quo=0, rem=0, div_by_zero=0.
- Internal count and partial registers clear.

States:
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch the dividend into the quotient shift register Q and the divisor into D;
  - clear the partial remainder R (WIDTH+1 bits);
  - count=WIDTH-1.
  - If in2==0: go to DONE with quo=all-ones, rem=in1, div_by_zero=1.
  - Otherwise go to CALC.
- CALC: in_ready=0. Each cycle:
  - T = {R[WIDTH-1:0], Q[MSB]}.
  - S = T − {0,D} via the slice chain (WIDTH/4 slices plus a top borrow bit).
  - No borrow: R=S, shift 1 into the Q LSB. Borrow: R=T, shift 0.
  - Q shifts left every cycle.
  - After the count==0 iteration, go to DONE.
- DONE: out_valid=1, quo=Q, rem=R[WIDTH-1:0].
  - Hold all outputs stable while out_ready=0.
  - On out_ready: out_valid=0 and go to IDLE.

Latency and throughput:
- out_valid rises WIDTH+1 cycles after the accepting edge; divide-by-zero rises after 1 cycle.
- Throughput is one division per WIDTH+2 cycles minimum.
- No new operand is accepted while in CALC or DONE; in_ready is registered and low there.

Ordering rules:
- Outputs quo, rem and div_by_zero keep their last values in IDLE.
- They update only on entry to DONE.
- in_valid asserted during CALC/DONE is ignored; the source must hold it until in_ready.
- out_ready asserted without out_valid has no effect.

Reset mid-operation: aborts immediately. No partial result is ever presented.

Arithmetic invariant: in1 == quo*in2 + rem, and rem < in2, for every in2≠0.

Optional Feature:
Macro MAS_DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if in2≠0 and in1<in2 (one extra slice-chain compare on the raw operands), skip CALC. Go to DONE next cycle with quo=0, rem=in1, div_by_zero=0 (latency 1).
- Not defined: the comparator is absent and every nonzero-divisor operation takes the full WIDTH+1 cycles with identical numeric results.

Test Plan:
1. WIDTH=8, in1=200, in2=7, out_ready=1 -> out_valid exactly 9 cycles after accept; quo=28, rem=4, div_by_zero=0.
2. in1=255, in2=1 -> quo=255, rem=0; then 0/9 (macro undefined) -> quo=0, rem=0 after 9 cycles.
3. in1=13, in2=0 -> out_valid after 1 cycle; quo=0xFF, rem=13, div_by_zero=1.
4. 100/10 with out_ready held low 5 cycles after out_valid:
   - quo=10 and rem=0 stay stable, in_ready stays 0;
   - a second in_valid is not accepted until one cycle after the out handshake.
5. Assert rst_n=0 at cycle 4 of CALC -> same cycle out_valid=0, in_ready=1; the next operation 9/4 returns quo=2, rem=1.
6. MAS_DIV_EARLY_EXIT_EN defined: 5/9 -> out_valid after 1 cycle, quo=0, rem=5; 9/5 -> full latency, quo=1, rem=4. Random 10k-pair sweep checks the invariant.

Source files
------------

// File: rtl/mas_seq_divider.sv
// mas_seq_divider: sequential restoring divider that produces one quotient bit per cycle.
// Optional macro MAS_DIV_EARLY_EXIT_EN: finish in one cycle when the dividend is below the divisor.
`default_nettype none

module mas_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
      $error("mas_seq_divider: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_part;
  logic [CW-1:0]    count;

  // a + ~b + 1 through 4-bit ripple slices; the MSB of the result is the carry-out (no borrow).
  function automatic logic [WIDTH:0] slice_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic             c;
    logic [4:0]       sc;
    logic [WIDTH-1:0] s;
    logic             ab;
    logic             bb;
    c  = 1'b1;
    sc = '0;
    s  = '0;
    for (int k = 0; k < WIDTH / 4; k++) begin
      sc[0] = c;
      for (int j = 0; j < 4; j++) begin
        ab          = a[4*k+j];
        bb          = ~b[4*k+j];
        s[4*k+j]    = ab ^ bb ^ sc[j];
        sc[j+1]     = (ab & bb) | (sc[j] & (ab ^ bb));
      end
      c = sc[4];
    end
    return {c, s};
  endfunction

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   low_sub;
  logic             no_borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             early_exit;

  assign trial     = {r_part, q_sh[WIDTH-1]};
  assign low_sub   = slice_sub(trial[WIDTH-1:0], d_reg);
  // Top borrow bit: subtracting the zero-extended divisor's MSB (0) from trial[WIDTH].
  assign no_borrow = trial[WIDTH] | low_sub[WIDTH];
  // The partial remainder stays below the divisor, so the top bit of S is always zero.
  assign r_next    = no_borrow ? low_sub[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next    = {q_sh[WIDTH-2:0], no_borrow};

`ifdef MAS_DIV_EARLY_EXIT_EN
  logic [WIDTH:0] cmp;
  assign cmp        = slice_sub(in1, in2);
  // A borrow implies in1 != in2, so the wrapped difference is necessarily nonzero.
  assign early_exit = ~cmp[WIDTH] & (|cmp[WIDTH-1:0]);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      q_sh        <= '0;
      d_reg       <= '0;
      r_part      <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_sh     <= in1;
            d_reg    <= in2;
            r_part   <= '0;
            count    <= CW'(WIDTH - 1);
            in_ready <= 1'b0;
            if (in2 == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quo         <= '1;
              rem         <= in1;
              div_by_zero <= 1'b1;
            end else if (early_exit) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quo         <= '0;
              rem         <= in1;
              div_by_zero <= 1'b0;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          r_part <= r_next;
          q_sh   <= q_next;
          count  <= count - 1'b1;
          if (count == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quo         <= q_next;
            rem         <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mas_seq_divider.sv
// tb_mas_seq_divider: randomized self-checking bench comparing the divider against plain arithmetic.
`default_nettype none

module tb_mas_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int checks;
  int errors;

  mas_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quo         (quo),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division, plus the divide-by-zero convention.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    int           elat;
    int           n;
    if (b == 0) begin
      eq = '1; er = a; edz = 1'b1; elat = 1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; elat = W + 1;
`ifdef MAS_DIV_EARLY_EXIT_EN
      if (a < b) elat = 1;
`endif
    end

    check("accept_ready", {31'd0, in_ready}, 32'd1);
    in1 = a; in2 = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in1 = W'($urandom); in2 = W'($urandom);

    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) check("busy_ready", {31'd0, in_ready}, 32'd0);
    end while (!out_valid && n < 40);

    check("latency", n, elat);
    check("quo", {24'd0, quo}, {24'd0, eq});
    check("rem", {24'd0, rem}, {24'd0, er});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
    check("done_ready", {31'd0, in_ready}, 32'd0);
    if (b != 0) begin
      check("invariant", quo * b + rem, {24'd0, a});
      check("rem_lt_div", {31'd0, rem < b}, 32'd1);
    end

    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in1 = W'($urandom); in2 = W'($urandom);
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_quo", {24'd0, quo}, {24'd0, eq});
      check("hold_rem", {24'd0, rem}, {24'd0, er});
      check("hold_ready", {31'd0, in_ready}, 32'd0);
    end

    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_ready", {31'd0, in_ready}, 32'd1);
    check("idle_quo", {24'd0, quo}, {24'd0, eq});
    check("idle_rem", {24'd0, rem}, {24'd0, er});
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           sel;
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quo", {24'd0, quo}, 32'd0);
    check("rst_rem", {24'd0, rem}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd200, 8'd7, 0);
    run_op(8'd255, 8'd1, 0);
    run_op(8'd0, 8'd9, 0);
    run_op(8'd13, 8'd0, 0);
    run_op(8'd100, 8'd10, 5);
    run_op(8'd50, 8'd5, 0);
    run_op(8'd5, 8'd9, 0);
    run_op(8'd9, 8'd5, 2);

    // Abort mid-calculation with an asynchronous reset.
    in1 = 8'd200; in2 = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_quo", {24'd0, quo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    run_op(8'd9, 8'd4, 0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      ra  = W'($urandom);
      if (sel == 0)      rb = '0;
      else if (sel < 4)  rb = W'($urandom_range(1, 15));
      else               rb = W'($urandom);
      run_op(ra, rb, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
